// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// selects and register-address width.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // A producer matches a consumer only if it writes back to a non-x0 register.
    function automatic logic rd_hit(input logic                  wb_en,
                                    input logic [REG_ADDR_W-1:0] rd,
                                    input logic [REG_ADDR_W-1:0] rs);
        return wb_en && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: stage register addresses and
// flags in, stage enables/flushes, forwarding selects and status out.
interface pipeline_hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    logic [REG_ADDR_W-1:0] id_rs1, id_rs2;
    logic                  id_use_rs1, id_use_rs2;
    logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic                  ex_mem_read, ex_branch_tkn;
    logic [REG_ADDR_W-1:0] mem_rd, wb_rd;
    logic                  mem_reg_wb, wb_reg_wb;
    logic                  mem_req, mem_ready;

    logic                  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic                  if_id_flush, id_ex_flush, mem_wb_flush;
    logic [1:0]            fwd_a, fwd_b;
    logic                  mem_err;
    logic [CNT_W-1:0]      stall_cycles, flush_events, lu_stalls;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_mem_read, ex_branch_tkn, mem_rd, mem_reg_wb, wb_rd, wb_reg_wb,
               mem_req, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush, fwd_a, fwd_b, mem_err,
               stall_cycles, flush_events, lu_stalls
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rs1, ex_rs2, ex_rd,
               ex_mem_read, ex_branch_tkn, mem_rd, mem_reg_wb, wb_rd, wb_reg_wb,
               mem_req, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_wb_flush, fwd_a, fwd_b, mem_err,
               stall_cycles, flush_events, lu_stalls
    );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding select for one EX source register. The younger EX/MEM
// result wins over MEM/WB; x0 is never forwarded.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_wb,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_wb,
    input  logic                  force_rf,
    output fwd_sel_t              sel
);

    // Pick the youngest matching producer unless forwarding is disabled.
    always_comb begin
        sel = FWD_RF;
        if (!force_rf) begin
            if (rd_hit(mem_reg_wb, mem_rd, rs)) begin
                sel = FWD_MEM;
            end else if (rd_hit(wb_reg_wb, wb_rd, rs)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage RV32 pipeline.
// Optional build macro STALL_STATS_EN adds saturating stall/flush statistics;
// without it the statistics ports read as zero.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal operation; branch flush / load-use stall resolved here
// MEM_WAIT | data memory access outstanding, pipeline frozen until ready
// ERR      | memory timed out; everything held, mem_err set until reset
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int                WCNT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    hz_state_t         state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              freeze;
    logic              lu_hit;
    logic              fwd_force_rf;
    fwd_sel_t          fwd_a_sel, fwd_b_sel;

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Memory-wait tracking; the counter holds the number of wait cycles so far.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        freeze  = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    freeze  = 1'b1;
                    wcnt_d  = WCNT_W'(1);
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (!bus.mem_ready) begin
                    freeze = 1'b1;
                    if (wcnt_q == WCNT_LAST) begin
                        state_d = ERR;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end else begin
                    wcnt_d  = '0;
                    state_d = RUN;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    assign lu_hit = bus.ex_mem_read && (bus.ex_rd != '0) &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    // Stage enables and bubbles, highest-priority condition first.
    always_comb begin
        bus.pc_en        = 1'b1;
        bus.if_id_en     = 1'b1;
        bus.id_ex_en     = 1'b1;
        bus.ex_mem_en    = 1'b1;
        bus.mem_wb_en    = 1'b1;
        bus.if_id_flush  = 1'b0;
        bus.id_ex_flush  = 1'b0;
        bus.mem_wb_flush = 1'b0;
        if (reset) begin
            bus.pc_en        = 1'b0;
            bus.if_id_en     = 1'b0;
            bus.id_ex_en     = 1'b0;
            bus.ex_mem_en    = 1'b0;
            bus.mem_wb_en    = 1'b0;
            bus.if_id_flush  = 1'b1;
            bus.id_ex_flush  = 1'b1;
            bus.mem_wb_flush = 1'b1;
        end else if (state_q == ERR) begin
            bus.pc_en     = 1'b0;
            bus.if_id_en  = 1'b0;
            bus.id_ex_en  = 1'b0;
            bus.ex_mem_en = 1'b0;
            bus.mem_wb_en = 1'b0;
        end else if (freeze) begin
            // WB keeps draining, but gets a bubble since MEM has no result yet.
            bus.pc_en        = 1'b0;
            bus.if_id_en     = 1'b0;
            bus.id_ex_en     = 1'b0;
            bus.ex_mem_en    = 1'b0;
            bus.mem_wb_flush = 1'b1;
        end else if (bus.ex_branch_tkn) begin
            // The dependent instruction is squashed anyway, so no load-use bubble.
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (lu_hit) begin
            bus.pc_en       = 1'b0;
            bus.if_id_en    = 1'b0;
            bus.id_ex_flush = 1'b1;
        end
    end

    assign bus.mem_err  = !reset && (state_q == ERR);
    assign fwd_force_rf = reset || (state_q == ERR);

    hazard_fwd_sel u_fwd_a (
        .rs         (bus.ex_rs1),
        .mem_rd     (bus.mem_rd),
        .mem_reg_wb (bus.mem_reg_wb),
        .wb_rd      (bus.wb_rd),
        .wb_reg_wb  (bus.wb_reg_wb),
        .force_rf   (fwd_force_rf),
        .sel        (fwd_a_sel)
    );

    hazard_fwd_sel u_fwd_b (
        .rs         (bus.ex_rs2),
        .mem_rd     (bus.mem_rd),
        .mem_reg_wb (bus.mem_reg_wb),
        .wb_rd      (bus.wb_rd),
        .wb_reg_wb  (bus.wb_reg_wb),
        .force_rf   (fwd_force_rf),
        .sel        (fwd_b_sel)
    );

    assign bus.fwd_a = fwd_a_sel;
    assign bus.fwd_b = fwd_b_sel;

`ifdef STALL_STATS_EN
    logic             active;
    logic             stall_inc, flush_inc, lu_inc;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;
    logic [CNT_W-1:0] lu_stalls_q, lu_stalls_d;

    // Classify this cycle with the same priority as the enable logic.
    always_comb begin
        active    = (state_q != ERR);
        flush_inc = active && !freeze && bus.ex_branch_tkn;
        lu_inc    = active && !freeze && !bus.ex_branch_tkn && lu_hit;
        stall_inc = (active && freeze) || lu_inc;
    end

    // Saturating increments.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        lu_stalls_d    = lu_stalls_q;
        if (stall_inc && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
        if (flush_inc && (flush_events_q != '1)) flush_events_d = flush_events_q + 1'b1;
        if (lu_inc && (lu_stalls_q != '1))       lu_stalls_d    = lu_stalls_q + 1'b1;
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
            lu_stalls_q    <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
            lu_stalls_q    <= lu_stalls_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_events = flush_events_q;
    assign bus.lu_stalls    = lu_stalls_q;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_events = '0;
    assign bus.lu_stalls    = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios followed by random traffic, all checked each cycle
// against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
    localparam int MT    = 4;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (hif.slave)
    );

    int checks = 0;
    int errors = 0;

    // model: in_access = an access has been stalled and not yet completed,
    // unready = consecutive unready cycles of that access, hung = timed out
    bit               in_access;
    int               unready;
    bit               hung;
    logic [CNT_W-1:0] m_stall, m_flush, m_lu;

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (hif.mem_reg_wb && hif.mem_rd != 0 && hif.mem_rd == rs) return 2'b10;
        if (hif.wb_reg_wb && hif.wb_rd != 0 && hif.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1;
    endfunction

    task automatic idle_inputs();
        hif.id_rs1 = 0; hif.id_rs2 = 0; hif.id_use_rs1 = 0; hif.id_use_rs2 = 0;
        hif.ex_rs1 = 0; hif.ex_rs2 = 0; hif.ex_rd = 0;
        hif.ex_mem_read = 0; hif.ex_branch_tkn = 0;
        hif.mem_rd = 0; hif.mem_reg_wb = 0; hif.wb_rd = 0; hif.wb_reg_wb = 0;
        hif.mem_req = 0; hif.mem_ready = 0;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Inputs are already applied; check outputs, then clock the model and DUT.
    task automatic cyc(input string tag);
        bit frz, dep, br, lu;
        logic [4:0] e_en;
        logic [2:0] e_fl;
        logic [1:0] e_fa, e_fb;
        logic e_err;
        logic [12:0] e_vec, o_vec;
        logic [3*CNT_W-1:0] e_st, o_st;
        #2;
        frz = !hung && ((in_access && !hif.mem_ready) ||
                        (!in_access && hif.mem_req && !hif.mem_ready));
        dep = hif.ex_mem_read && hif.ex_rd != 0 &&
              ((hif.id_use_rs1 && hif.id_rs1 == hif.ex_rd) ||
               (hif.id_use_rs2 && hif.id_rs2 == hif.ex_rd));
        br = !hung && !frz && hif.ex_branch_tkn;
        lu = !hung && !frz && !hif.ex_branch_tkn && dep;
        e_err = 0; e_fa = 0; e_fb = 0;
        if (reset) begin
            e_en = 5'b00000; e_fl = 3'b111;
        end else if (hung) begin
            e_en = 5'b00000; e_fl = 3'b000; e_err = 1;
        end else begin
            e_fa = fwd_ref(hif.ex_rs1);
            e_fb = fwd_ref(hif.ex_rs2);
            if (frz)     begin e_en = 5'b00001; e_fl = 3'b001; end
            else if (br) begin e_en = 5'b11111; e_fl = 3'b110; end
            else if (lu) begin e_en = 5'b00111; e_fl = 3'b010; end
            else         begin e_en = 5'b11111; e_fl = 3'b000; end
        end
        e_vec = {e_en, e_fl, e_fa, e_fb, e_err};
        o_vec = {hif.pc_en, hif.if_id_en, hif.id_ex_en, hif.ex_mem_en, hif.mem_wb_en,
                 hif.if_id_flush, hif.id_ex_flush, hif.mem_wb_flush,
                 hif.fwd_a, hif.fwd_b, hif.mem_err};
        checks++;
        assert (o_vec === e_vec) else begin
            errors++;
            $error("FAIL %s ctrl {en5,fl3,fa,fb,err}: observed %b expected %b", tag, o_vec, e_vec);
        end
`ifdef STALL_STATS_EN
        e_st = {m_stall, m_flush, m_lu};
`else
        e_st = '0;
`endif
        o_st = {hif.stall_cycles, hif.flush_events, hif.lu_stalls};
        checks++;
        assert (o_st === e_st) else begin
            errors++;
            $error("FAIL %s stats {stall,flush,lu}: observed %h expected %h", tag, o_st, e_st);
        end
        @(posedge clk);
        if (reset) begin
            in_access = 0; unready = 0; hung = 0;
            m_stall = 0; m_flush = 0; m_lu = 0;
        end else if (!hung) begin
            if (frz || lu) m_stall = sat_inc(m_stall);
            if (br) m_flush = sat_inc(m_flush);
            if (lu) m_lu = sat_inc(m_lu);
            if (frz) begin
                in_access = 1;
                unready++;
                if (unready == MT) hung = 1;
            end else if (in_access && hif.mem_ready) begin
                in_access = 0;
                unready = 0;
            end
        end
        #1;
    endtask

    initial begin
        in_access = 0; unready = 0; hung = 0;
        m_stall = 0; m_flush = 0; m_lu = 0;
        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        cyc("reset0");
        check_bit("reset_pc_en", hif.pc_en, 1'b0);
        cyc("reset1");
        reset = 0;
        cyc("idle");

        // load-use: ld x5 in EX, add x6,x5,x1 in ID
        hif.ex_mem_read = 1; hif.ex_rd = 5;
        hif.id_rs1 = 5; hif.id_use_rs1 = 1; hif.id_rs2 = 1; hif.id_use_rs2 = 1;
        #2;
        check_bit("lu_pc_en", hif.pc_en, 1'b0);
        check_bit("lu_id_ex_flush", hif.id_ex_flush, 1'b1);
        cyc("lu_bubble");
        hif.ex_mem_read = 0; hif.ex_rd = 0;
        cyc("lu_after");

        // taken branch masks the load-use
        hif.ex_mem_read = 1; hif.ex_rd = 5; hif.ex_branch_tkn = 1;
        #2;
        check_bit("br_pc_en", hif.pc_en, 1'b1);
        cyc("br_over_lu");
        idle_inputs();
        cyc("br_after");

        // three wait cycles then ready
        hif.mem_req = 1; hif.mem_ready = 0;
        for (int i = 0; i < 3; i++) cyc("wait3");
        hif.mem_ready = 1;
        cyc("wait3_release");
        idle_inputs();
        cyc("wait3_after");

        // mem_ready without mem_req is ignored, ready with req does not freeze
        hif.mem_ready = 1;
        cyc("ready_noreq");
        hif.mem_req = 1;
        cyc("req_ready");
        idle_inputs();

        // forwarding priorities
        hif.mem_rd = 7; hif.wb_rd = 7; hif.ex_rs1 = 7; hif.ex_rs2 = 7;
        hif.mem_reg_wb = 1; hif.wb_reg_wb = 1;
        #2;
        checks++;
        assert (hif.fwd_a === 2'b10) else begin
            errors++;
            $error("FAIL fwd_mem_prio: observed %b expected 10", hif.fwd_a);
        end
        cyc("fwd_both");
        hif.mem_reg_wb = 0;
        cyc("fwd_wb");
        hif.mem_rd = 0; hif.wb_rd = 0; hif.ex_rs1 = 0; hif.mem_reg_wb = 1;
        cyc("fwd_x0");
        idle_inputs();

        // hung memory -> ERR, then reset
        hif.mem_req = 1; hif.mem_ready = 0;
        hif.mem_rd = 3; hif.mem_reg_wb = 1; hif.ex_rs1 = 3;
        for (int i = 0; i < MT + 3; i++) cyc("timeout");
        check_bit("timeout_err", hif.mem_err, 1'b1);
        hif.mem_ready = 1;
        cyc("err_sticky");
        reset = 1;
        cyc("err_reset");
        reset = 0;
        idle_inputs();
        check_bit("err_cleared", hif.mem_err, 1'b0);
        cyc("post_err");

        // reset in the middle of a wait
        hif.mem_req = 1; hif.mem_ready = 0;
        cyc("midwait0");
        cyc("midwait1");
        reset = 1;
        cyc("midwait_reset");
        reset = 0;
        idle_inputs();
        cyc("midwait_run");

        // random traffic with small register numbers to create collisions
        for (int n = 0; n < 3000; n++) begin
            hif.id_rs1 = 5'($urandom_range(0, 3));
            hif.id_rs2 = 5'($urandom_range(0, 3));
            hif.id_use_rs1 = 1'($urandom);
            hif.id_use_rs2 = 1'($urandom);
            hif.ex_rs1 = 5'($urandom_range(0, 3));
            hif.ex_rs2 = 5'($urandom_range(0, 3));
            hif.ex_rd = 5'($urandom_range(0, 3));
            hif.ex_mem_read = 1'($urandom);
            hif.ex_branch_tkn = ($urandom_range(0, 4) == 0);
            hif.mem_rd = 5'($urandom_range(0, 3));
            hif.mem_reg_wb = 1'($urandom);
            hif.wb_rd = 5'($urandom_range(0, 3));
            hif.wb_reg_wb = 1'($urandom);
            hif.mem_req = ($urandom_range(0, 2) == 0);
            hif.mem_ready = ($urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 60) == 0) || (hung && $urandom_range(0, 3) == 0);
            cyc("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
